// File: rtl/bus_arb_pkg.sv
// Shared encodings for the two-master bus arbiter: FSM states and master IDs.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RDATA  = 2'd2
    } arb_state_t;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner selection for bus_arbiter. Define BUS_ARB_ROUND_ROBIN_EN
// for round-robin conflict resolution; default build is fixed priority (m0 wins).
module bus_arb_pick
    import bus_arb_pkg::*;
(
    input  logic m0_req,
    input  logic m1_req,
    input  logic m1_lock,
    input  logic active,   // a bus session is in progress, so the owner is meaningful
    input  logic owner,    // last granted master; doubles as the round-robin pointer
    output logic grant,
    output logic winner
);

    always_comb begin
        grant  = m0_req | m1_req;
        winner = ARB_M0;
        if (active && (owner == ARB_M1) && m1_lock && m1_req) begin
            winner = ARB_M1;
        end else if (m0_req && m1_req) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
            winner = (owner == ARB_M0) ? ARB_M1 : ARB_M0;
`else
            winner = ARB_M0;
`endif
        end else if (m1_req) begin
            winner = ARB_M1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter (CPU = m0, DMA = m1): address phase, read data phase,
// CPU stall and locked m1 bursts. BUS_ARB_ROUND_ROBIN_EN selects round-robin in bus_arb_pick.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m0_wen,
    input  logic          m1_wen,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m_rdata,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic          bus_ren,
    output logic          bus_wen,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_busy,
    output logic          cpu_stall
);

    arb_state_t    state_reg;
    logic          owner_reg;
    logic [DW-1:0] rdata_hold_reg;

    logic active;
    logic decision;
    logic take;
    logic pick_grant;
    logic pick_winner;

    assign active   = (state_reg != ARB_IDLE);
    // A read in ACCESS always proceeds to RDATA, so it is never a decision point.
    assign decision = (state_reg == ARB_IDLE) || (state_reg == ARB_RDATA) ||
                      ((state_reg == ARB_ACCESS) && bus_wen);
    assign take     = decision && pick_grant && !bus_busy;

    bus_arb_pick u_pick (
        .m0_req  (m0_req),
        .m1_req  (m1_req),
        .m1_lock (m1_lock),
        .active  (active),
        .owner   (owner_reg),
        .grant   (pick_grant),
        .winner  (pick_winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARB_IDLE;
            owner_reg      <= ARB_M1;
            rdata_hold_reg <= '0;
            m0_gnt         <= 1'b0;
            m1_gnt         <= 1'b0;
            m0_rvalid      <= 1'b0;
            m1_rvalid      <= 1'b0;
            bus_ren        <= 1'b0;
            bus_wen        <= 1'b0;
            bus_addr       <= '0;
            bus_wdata      <= '0;
        end else begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            bus_ren   <= 1'b0;
            bus_wen   <= 1'b0;
            if (state_reg == ARB_RDATA) begin
                rdata_hold_reg <= bus_rdata;
            end
            if ((state_reg == ARB_ACCESS) && bus_ren) begin
                state_reg <= ARB_RDATA;
                if (owner_reg == ARB_M1) begin
                    m1_rvalid <= 1'b1;
                end else begin
                    m0_rvalid <= 1'b1;
                end
            end else if (take) begin
                state_reg <= ARB_ACCESS;
                owner_reg <= pick_winner;
                if (pick_winner == ARB_M1) begin
                    m1_gnt    <= 1'b1;
                    bus_addr  <= m1_addr;
                    bus_wdata <= m1_wdata;
                    bus_wen   <= m1_wen;
                    bus_ren   <= !m1_wen;
                end else begin
                    m0_gnt    <= 1'b1;
                    bus_addr  <= m0_addr;
                    bus_wdata <= m0_wdata;
                    bus_wen   <= m0_wen;
                    bus_ren   <= !m0_wen;
                end
            end else begin
                state_reg <= ARB_IDLE;
            end
        end
    end

    // Slave data arrives during RDATA; forward it then and hold the captured copy afterwards.
    assign m_rdata   = (state_reg == ARB_RDATA) ? bus_rdata : rdata_hold_reg;
    assign cpu_stall = m0_req & !(m0_gnt & m0_wen) & !m0_rvalid;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: per-master expected accesses queued when driven,
// checked on gnt; expected read data queued on gnt, checked on rvalid.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_wen = 1'b0, m1_wen = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m1_lock = 1'b0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m_rdata, bus_addr, bus_wdata;
    logic        bus_ren, bus_wen;
    logic [31:0] bus_rdata = '0;
    logic        bus_busy = 1'b0;
    logic        cpu_stall;

    typedef struct {
        logic        wen;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dcyc;
    } cmd_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rexp_t;

    cmd_t  m0q[$], m1q[$], e0[$], e1[$];
    rexp_t r0[$], r1[$];
    int    glog_m[$], glog_c[$], glog_l[$];
    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    logic [31:0] rd_xor = '0;

    bus_arbiter #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m1_req    (m1_req),
        .m0_wen    (m0_wen),
        .m1_wen    (m1_wen),
        .m0_addr   (m0_addr),
        .m1_addr   (m1_addr),
        .m0_wdata  (m0_wdata),
        .m1_wdata  (m1_wdata),
        .m1_lock   (m1_lock),
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_rvalid (m1_rvalid),
        .m_rdata   (m_rdata),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ren   (bus_ren),
        .bus_wen   (bus_wen),
        .bus_rdata (bus_rdata),
        .bus_busy  (bus_busy),
        .cpu_stall (cpu_stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: read data valid the cycle after bus_ren.
    always @(posedge clk) if (bus_ren) bus_rdata <= bus_addr ^ rd_xor;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic cmd_t mk(input logic wen, input logic lock, input logic [31:0] addr,
                                input logic [31:0] wdata);
        cmd_t c;
        c.wen = wen; c.lock = lock; c.addr = addr; c.wdata = wdata;
        c.rdata = addr ^ rd_xor; c.dcyc = 0;
        return c;
    endfunction

    // Masters release the current request in its gnt cycle and present the next one at once.
    initial begin
        cmd_t c;
        forever begin
            @(posedge clk); #1;
            if (m0_gnt) m0_req = 1'b0;
            if (!m0_req && m0q.size() > 0) begin
                c = m0q.pop_front();
                c.dcyc = cyc;
                m0_req = 1'b1; m0_wen = c.wen; m0_addr = c.addr; m0_wdata = c.wdata;
                e0.push_back(c);
            end
        end
    end

    initial begin
        cmd_t c;
        forever begin
            @(posedge clk); #1;
            if (m1_gnt) begin m1_req = 1'b0; m1_lock = 1'b0; end
            if (!m1_req && m1q.size() > 0) begin
                c = m1q.pop_front();
                c.dcyc = cyc;
                m1_req = 1'b1; m1_wen = c.wen; m1_addr = c.addr; m1_wdata = c.wdata;
                m1_lock = c.lock;
                e1.push_back(c);
            end
        end
    end

    task automatic on_gnt(input int m);
        cmd_t  c;
        rexp_t r;
        int    n;
        n = (m == 1) ? e1.size() : e0.size();
        check($sformatf("m%0d_gnt_pending", m), n > 0, 1'b1);
        if (n > 0) begin
            c = (m == 1) ? e1.pop_front() : e0.pop_front();
            check($sformatf("m%0d_addr", m), bus_addr, c.addr);
            check($sformatf("m%0d_wen", m), bus_wen, c.wen);
            check($sformatf("m%0d_ren", m), bus_ren, !c.wen);
            if (c.wen) check($sformatf("m%0d_wdata", m), bus_wdata, c.wdata);
            else begin
                r.data = c.rdata; r.cyc = cyc + 1;
                if (m == 1) r1.push_back(r); else r0.push_back(r);
            end
            glog_m.push_back(m); glog_c.push_back(cyc); glog_l.push_back(cyc - c.dcyc);
            $display("cycle %0d: m%0d gnt %s addr=%h wdata=%h", cyc, m, c.wen ? "WR" : "RD",
                     bus_addr, bus_wdata);
        end
    endtask

    task automatic on_rvalid(input int m);
        rexp_t r;
        int    n;
        n = (m == 1) ? r1.size() : r0.size();
        check($sformatf("m%0d_rvalid_pending", m), n > 0, 1'b1);
        if (n > 0) begin
            r = (m == 1) ? r1.pop_front() : r0.pop_front();
            check($sformatf("m%0d_rdata", m), m_rdata, r.data);
            check($sformatf("m%0d_rvalid_cycle", m), cyc, r.cyc);
            $display("cycle %0d: m%0d rvalid rdata=%h", cyc, m, m_rdata);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("single_gnt", {m0_gnt, m1_gnt} == 2'b11, 1'b0);
            if (!m0_gnt && !m1_gnt) check("bus_quiet", {bus_ren, bus_wen}, 2'b00);
            check("cpu_stall", cpu_stall, m0_req & !(m0_gnt & m0_wen) & !m0_rvalid);
            if (m0_gnt) on_gnt(0);
            if (m1_gnt) on_gnt(1);
            if (m0_rvalid) on_rvalid(0);
            if (m1_rvalid) on_rvalid(1);
        end
    end

    task automatic wait_grants(input int n);
        int k = 0;
        while (glog_m.size() < n && k < 300) begin @(negedge clk); k++; end
        check("grant_count", glog_m.size(), n);
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((m0q.size() + m1q.size() + e0.size() + e1.size() + r0.size() + r1.size()) != 0
               && k < 300) begin
            @(negedge clk); k++;
        end
        check("drain", m0q.size() + m1q.size() + e0.size() + e1.size() + r0.size() + r1.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, {m0_gnt, m1_gnt}, 2'b00);
        check({tag, "_rvalid"}, {m0_rvalid, m1_rvalid}, 2'b00);
        check({tag, "_ren_wen"}, {bus_ren, bus_wen}, 2'b00);
        check({tag, "_addr"}, bus_addr, 32'h0);
        check({tag, "_wdata"}, bus_wdata, 32'h0);
        check({tag, "_rdata"}, m_rdata, 32'h0);
    endtask

    initial begin
        int base, b, last;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        // Single m0 write: gnt one cycle after the request appears.
        repeat (2) @(negedge clk);
        base = glog_m.size();
        m0q.push_back(mk(1'b1, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF));
        wait_grants(base + 1);
        check("wr_master", glog_m[base], 0);
        check("wr_latency", glog_l[base], 1);

        // Single m1 read.
        repeat (2) @(negedge clk);
        rd_xor = 32'h1234_5678;
        base = glog_m.size();
        m1q.push_back(mk(1'b0, 1'b0, 32'h0000_0000, 32'h0));
        wait_grants(base + 1);
        check("rd_master", glog_m[base], 1);
        check("rd_latency", glog_l[base], 1);
        wait_drain();

        // Continuous reads from both masters.
        rd_xor = 32'hA5A5_0000;
        base = glog_m.size();
        for (int i = 0; i < 4; i++) begin
            m0q.push_back(mk(1'b0, 1'b0, 32'h100 + 32'(4 * i), 32'h0));
            m1q.push_back(mk(1'b0, 1'b0, 32'h200 + 32'(4 * i), 32'h0));
        end
        wait_grants(base + 8);
        for (int i = 0; i < 8; i++) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
            check($sformatf("conflict_order_%0d", i), glog_m[base + i], i % 2);
`else
            check($sformatf("conflict_order_%0d", i), glog_m[base + i], (i >= 4) ? 1 : 0);
`endif
        end
        wait_drain();

        // Locked m1 burst; m0 arrives during beat 2.
        base = glog_m.size();
        for (int i = 0; i < 4; i++)
            m1q.push_back(mk(1'b1, 1'b1, 32'h3000 + 32'(4 * i), 32'(i + 1)));
        wait_grants(base + 1);
        m0q.push_back(mk(1'b1, 1'b0, 32'h0000_4000, 32'hCAFE_0001));
        wait_grants(base + 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("burst_master_%0d", i), glog_m[base + i], (i < 4) ? 1 : 0);
            check($sformatf("burst_cycle_%0d", i), glog_c[base + i], glog_c[base] + i);
        end
        wait_drain();

        // bus_busy blocks the grant for five cycles.
        base = glog_m.size();
        m0q.push_back(mk(1'b1, 1'b0, 32'h0000_5000, 32'h5555_AAAA));
        @(posedge clk); #1 bus_busy = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus_busy = 1'b0;
        b = cyc;
        check("busy_no_gnt", glog_m.size(), base);
        wait_grants(base + 1);
        check("busy_release_cycle", glog_c[base], b + 1);
        wait_drain();

        // Reset in RDATA: read dropped, outputs cleared at once, then m0 wins a conflict.
        base = glog_m.size();
        m0q.push_back(mk(1'b0, 1'b0, 32'h0000_6000, 32'h0));
        wait_grants(base + 1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        r0.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m0q.push_back(mk(1'b1, 1'b0, 32'h0000_7000, 32'h7777_0000));
        m1q.push_back(mk(1'b1, 1'b0, 32'h0000_7004, 32'h7777_0004));
        wait_grants(base + 3);
        check("post_reset_first", glog_m[base + 1], 0);
        check("post_reset_second", glog_m[base + 2], 1);
        wait_drain();

        last = glog_m.size();
        repeat (3) @(negedge clk);
        check("no_stray_gnt", glog_m.size(), last);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
